pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 12 +
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/sat_counter.sv | 21 ++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-address sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        BUBBLE = 2'd2
    } seq_state_t;

    localparam int PC_INC = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/branch-unit/imem side of the PC sequencer, bundled as one port.
interface pc_sequencer_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             imem_ready;
    logic             PcSel;
    logic [31:0]      BrPC;
    logic [PC_W-1:0]  PC;
    logic             fetch_req;
    logic             flush_ifid;
    logic             flush_idex;
    logic             redirect_pend;
    logic             misalign;
    logic [CNT_W-1:0] br_count;

    modport master (
        output stall, imem_ready, PcSel, BrPC,
        input  PC, fetch_req, flush_ifid, flush_idex, redirect_pend, misalign, br_count
    );

    modport slave (
        input  stall, imem_ready, PcSel, BrPC,
        output PC, fetch_req, flush_ifid, flush_idex, redirect_pend, misalign, br_count
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch, stalls, and branch redirects that may
// have to wait for the instruction memory to accept the new address.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input logic             clk,
    input logic             reset,
    pc_sequencer_if.slave   bus
);
    seq_state_t      state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] pend_reg, pend_next;
    logic            fetch_reg;
    logic            misalign_reg;
    logic            flush_ifid_c, flush_idex_c;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pend_sel;

    // Word-aligned target; address bits beyond the PC width are dropped.
    assign target   = {bus.BrPC[PC_W-1:2], 2'b00};
    assign pend_sel = bus.PcSel ? target : pend_reg;

    generate
        if (PC_W < 32) begin : g_unused_hi
            logic unused_br_hi;
            assign unused_br_hi = ^bus.BrPC[31:PC_W];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        pend_next    = pend_reg;
        flush_ifid_c = 1'b0;
        flush_idex_c = 1'b0;
        unique case (state_reg)
            RUN, BUBBLE: begin
                flush_ifid_c = (state_reg == BUBBLE) || bus.PcSel;
                flush_idex_c = bus.PcSel;
                if (bus.PcSel) begin
                    // A redirect overrides any stall request.
                    if (bus.imem_ready) begin
                        pc_next    = target;
                        state_next = BUBBLE;
                    end else begin
                        pend_next  = target;
                        state_next = PEND;
                    end
                end else begin
                    state_next = RUN;
                    if (!bus.stall && bus.imem_ready) begin
                        pc_next = pc_reg + PC_W'(PC_INC);
                    end
                end
            end
            PEND: begin
                flush_ifid_c = 1'b1;
                flush_idex_c = bus.PcSel;
                if (bus.imem_ready) begin
                    pc_next    = pend_sel;
                    state_next = BUBBLE;
                end else begin
                    pend_next  = pend_sel;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= RUN;
            pc_reg       <= RESET_PC;
            pend_reg     <= '0;
            fetch_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            pend_reg  <= pend_next;
            fetch_reg <= 1'b1;
            if (bus.PcSel && (bus.BrPC[1:0] != 2'b00)) begin
                misalign_reg <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.PcSel),
        .count (bus.br_count)
    );

    // Flushes are combinational, so hold them low while reset is asserted.
    assign bus.flush_ifid    = flush_ifid_c & reset;
    assign bus.flush_idex    = flush_idex_c & reset;
    assign bus.PC            = pc_reg;
    assign bus.fetch_req     = fetch_reg;
    assign bus.redirect_pend = (state_reg == PEND);
    assign bus.misalign      = misalign_reg;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default instance plus a 2-bit-counter instance.
module tb_pc_sequencer;
    logic clk;
    logic reset;

    pc_sequencer_if #(.PC_W(9), .CNT_W(16)) bus1 ();
    pc_sequencer_if #(.PC_W(9), .CNT_W(2))  bus2 ();

    pc_sequencer #(.PC_W(9), .RESET_PC(9'h000), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    pc_sequencer #(.PC_W(9), .RESET_PC(9'h000), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    typedef struct {
        logic [8:0] pc;
        int         cnt;
        logic       rp;
        logic       mis;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic p, input logic [31:0] b);
        bus1.stall = s; bus1.imem_ready = r; bus1.PcSel = p; bus1.BrPC = b;
        bus2.stall = s; bus2.imem_ready = r; bus2.PcSel = p; bus2.BrPC = b;
    endtask

    task automatic chk_reset();
        chk("rst_pc",       32'(bus1.PC), 32'h0);
        chk("rst_fetch",    32'(bus1.fetch_req), 32'h0);
        chk("rst_flush_if", 32'(bus1.flush_ifid), 32'h0);
        chk("rst_flush_ex", 32'(bus1.flush_idex), 32'h0);
        chk("rst_pend",     32'(bus1.redirect_pend), 32'h0);
        chk("rst_mis",      32'(bus1.misalign), 32'h0);
        chk("rst_cnt",      32'(bus1.br_count), 32'h0);
        chk("rst_cnt2",     32'(bus2.br_count), 32'h0);
        $display("reset check pc=%0h fetch=%0b pend=%0b", bus1.PC, bus1.fetch_req, bus1.redirect_pend);
    endtask

    // Called at a falling edge: drive, check same-cycle flushes, then check
    // the registered state after the next rising edge against the queued entry.
    task automatic step(input logic s, input logic r, input logic p, input logic [31:0] b,
                        input logic fi, input logic fx,
                        input logic [8:0] npc, input int ncnt, input logic nrp, input logic nmis);
        exp_t e;
        drive(s, r, p, b);
        #1;
        chk("flush_ifid", 32'(bus1.flush_ifid), 32'(fi));
        chk("flush_idex", 32'(bus1.flush_idex), 32'(fx));
        exp_q.push_back('{pc: npc, cnt: ncnt, rp: nrp, mis: nmis});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("pc",            32'(bus1.PC), 32'(e.pc));
        chk("br_count",      32'(bus1.br_count), 32'(e.cnt));
        chk("br_count_sat",  32'(bus2.br_count), 32'((e.cnt > 3) ? 3 : e.cnt));
        chk("redirect_pend", 32'(bus1.redirect_pend), 32'(e.rp));
        chk("misalign",      32'(bus1.misalign), 32'(e.mis));
        chk("fetch_req",     32'(bus1.fetch_req), 32'h1);
        $display("step st=%0b rdy=%0b sel=%0b br=%0h -> pc=%0h cnt=%0d cnt2=%0d pend=%0b mis=%0b",
                 s, r, p, b, bus1.PC, bus1.br_count, bus2.br_count, bus1.redirect_pend, bus1.misalign);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        chk_reset();
        @(posedge clk);
        #1;
        chk_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        chk("rel_pc", 32'(bus1.PC), 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        // Redirect request during reset must not leak onto the flush outputs.
        drive(1'b0, 1'b0, 1'b1, 32'h100);
        @(posedge clk);
        #1;
        chk_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        chk("rel_pc", 32'(bus1.PC), 32'h0);

        // Free run from reset
        step(0,1,0,32'h0,    0,0, 9'h004, 0, 0, 0);
        step(0,1,0,32'h0,    0,0, 9'h008, 0, 0, 0);
        step(0,1,0,32'h0,    0,0, 9'h00C, 0, 0, 0);
        step(0,1,0,32'h0,    0,0, 9'h010, 0, 0, 0);

        pulse_reset();
        step(0,1,0,32'h0,    0,0, 9'h004, 0, 0, 0);
        step(0,1,0,32'h0,    0,0, 9'h008, 0, 0, 0);
        // Taken branch at PC=8 with memory ready
        step(0,1,1,32'h40,   1,1, 9'h040, 1, 0, 0);
        step(0,1,0,32'h0,    1,0, 9'h044, 1, 0, 0);
        step(0,1,0,32'h0,    0,0, 9'h048, 1, 0, 0);
        // Stall and not-ready both hold
        step(1,1,0,32'h0,    0,0, 9'h048, 1, 0, 0);
        step(0,0,0,32'h0,    0,0, 9'h048, 1, 0, 0);
        // Redirect waiting three cycles for memory
        step(0,0,1,32'h80,   1,1, 9'h048, 2, 1, 0);
        step(1,0,0,32'h0,    1,0, 9'h048, 2, 1, 0);
        step(0,0,0,32'h0,    1,0, 9'h048, 2, 1, 0);
        step(0,1,0,32'h0,    1,0, 9'h080, 2, 0, 0);
        step(0,1,0,32'h0,    1,0, 9'h084, 2, 0, 0);
        // Newest pending target wins
        step(0,0,1,32'h100,  1,1, 9'h084, 3, 1, 0);
        step(0,0,1,32'hC0,   1,1, 9'h084, 4, 1, 0);
        step(0,1,0,32'h0,    1,0, 9'h0C0, 4, 0, 0);
        step(0,1,0,32'h0,    1,0, 9'h0C4, 4, 0, 0);
        // Same-cycle target in PEND, then redirect from BUBBLE
        step(0,0,1,32'h10,   1,1, 9'h0C4, 5, 1, 0);
        step(0,1,1,32'h30,   1,1, 9'h030, 6, 0, 0);
        step(0,1,1,32'h50,   1,1, 9'h050, 7, 0, 0);
        step(0,1,0,32'h0,    1,0, 9'h054, 7, 0, 0);
        // Redirect beats stall
        step(1,1,1,32'h20,   1,1, 9'h020, 8, 0, 0);
        step(0,1,0,32'h0,    1,0, 9'h024, 8, 0, 0);
        // High target bits ignored
        step(0,1,1,32'hFFFFFE10, 1,1, 9'h010, 9, 0, 0);
        step(0,1,0,32'h0,    1,0, 9'h014, 9, 0, 0);
        // Misaligned target, then wrap past the top of the PC range
        step(0,1,1,32'h1FE,  1,1, 9'h1FC, 10, 0, 1);
        step(0,1,0,32'h0,    1,0, 9'h000, 10, 0, 1);
        step(0,1,0,32'h0,    0,0, 9'h004, 10, 0, 1);
        // Reset while a redirect is pending discards it
        step(0,0,1,32'h100,  1,1, 9'h004, 11, 1, 1);
        pulse_reset();
        step(0,1,0,32'h0,    0,0, 9'h004, 0, 0, 0);
        // Five back-to-back redirects: narrow counter saturates at 3
        step(0,1,1,32'h40,   1,1, 9'h040, 1, 0, 0);
        step(0,1,1,32'h60,   1,1, 9'h060, 2, 0, 0);
        step(0,1,1,32'h80,   1,1, 9'h080, 3, 0, 0);
        step(0,1,1,32'hA0,   1,1, 9'h0A0, 4, 0, 0);
        step(0,1,1,32'hC0,   1,1, 9'h0C0, 5, 0, 0);
        step(0,1,0,32'h0,    1,0, 9'h0C4, 5, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
